// File: rtl/key_expansion_iter_pkg.sv
// aes_pkg: shared AES key-schedule constants, state encoding and NK/NR lookups
// Holds the key-length codes, the Rcon table, the two-state FSM enum and
// helpers that map a key-length code onto NK (key words) and NR (rounds).
package aes_pkg;
  localparam logic [1:0] KEY_128 = 2'd0;
  localparam logic [1:0] KEY_192 = 2'd1;
  localparam logic [1:0] KEY_256 = 2'd2;
  localparam logic [1:0] KEY_RSVD = 2'd3;
  typedef enum logic {IDLE, EXPAND} state_t;
  // Entry 0 is never used; rc_j lives at index j.
  localparam logic [0:10][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic logic [3:0] nk_of(input logic [1:0] len);
    return len == KEY_128 ? 4'd4 : len == KEY_192 ? 4'd6 : 4'd8;
  endfunction
  function automatic logic [3:0] nr_of(input logic [1:0] len);
    return len == KEY_128 ? 4'd10 : len == KEY_192 ? 4'd12 : 4'd14;
  endfunction
endpackage

// File: rtl/key_expansion_iter_if.sv
// key_expansion_iter_if: request/readback bundle of the key expander
// Inputs : i_start, i_key_len, i_cypher_key (left-aligned), i_rk_idx
// Outputs: o_round_key, o_busy, o_done, o_key_valid, o_err
interface key_expansion_iter_if;
  logic i_start;
  logic [1:0] i_key_len;
  logic [255:0] i_cypher_key;
  logic [3:0] i_rk_idx;
  logic [127:0] o_round_key;
  logic o_busy;
  logic o_done;
  logic o_key_valid;
  logic o_err;
  modport master (output i_start, i_key_len, i_cypher_key, i_rk_idx,
                  input o_round_key, o_busy, o_done, o_key_valid, o_err);
  modport slave (input i_start, i_key_len, i_cypher_key, i_rk_idx,
                 output o_round_key, o_busy, o_done, o_key_valid, o_err);
endinterface

// File: rtl/key_expansion_iter_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel AES S-box lookups
// Ports: a = input word, y = substituted word (byte-wise)
module aes_sub_word (
  input  logic [31:0] a,
  output logic [31:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  for (genvar b = 0; b < 4; b++) begin : g_s
    assign y[8*b +: 8] = SBOX[a[8*b +: 8]];
  end
endmodule

// File: rtl/key_expansion_iter.sv
// key_expansion_iter: iterative AES-128/192/256 key schedule, one word per clock
// Ports: i_clk, i_rst_n (async, active-low), bus (slave side of key_expansion_iter_if)
// A start in IDLE loads w[0..NK-1]; EXPAND then derives one word per edge and
// returns to IDLE after writing the last word of round NR.
module key_expansion_iter
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = MAX_NK + 6
) (
  input logic i_clk,
  input logic i_rst_n,
  key_expansion_iter_if.slave bus
);
  localparam int WORDS = 4 * (MAX_NR + 1);
  localparam int IW = $clog2(WORDS + 1);
  state_t state, state_n;
  logic [31:0] w [WORDS];
  logic [IW-1:0] i, nk, last_i;
  logic [IW-3:0] rk;
  logic [3:0] nr, j;
  logic [2:0] m;
  logic reject, accept, last, valid, done, err;
  logic [31:0] prev, sw_in, sw_out, temp;
  aes_sub_word u_sub (.a(sw_in), .y(sw_out));
  // m tracks i mod NK and j tracks i/NK so no divider is needed.
  always_comb begin
    reject = bus.i_key_len == KEY_RSVD || int'(nk_of(bus.i_key_len)) > MAX_NK;
    accept = state == IDLE && bus.i_start && !reject;
    last_i = IW'({nr, 2'b11});
    last = state == EXPAND && i == last_i;
    state_n = accept ? EXPAND : last ? IDLE : state;
    prev = w[i - IW'(1)];
    sw_in = m == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    temp = m == 3'd0 ? sw_out ^ {RCON[j], 24'h0} :
           (nk == IW'(8) && m == 3'd4) ? sw_out : prev;
    rk = (IW-2)'(bus.i_rk_idx);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i <= '0;
      nk <= IW'(MAX_NK);
      nr <= 4'(MAX_NR);
      m <= '0;
      j <= '0;
      valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      for (int k = 0; k < WORDS; k++) w[k] <= '0;
    end else begin
      done <= last;
      err <= state == IDLE && bus.i_start && reject;
      if (accept) begin
        for (int k = 0; k < 8; k++)
          if (k < int'(nk_of(bus.i_key_len))) w[k] <= bus.i_cypher_key[255-32*k -: 32];
        i <= IW'(nk_of(bus.i_key_len));
        nk <= IW'(nk_of(bus.i_key_len));
        nr <= nr_of(bus.i_key_len);
        m <= '0;
        j <= 4'd1;
        valid <= 1'b0;
      end else if (state == EXPAND) begin
        w[i] <= w[i - nk] ^ temp;
        i <= i + IW'(1);
        m <= m == 3'(nk - IW'(1)) ? 3'd0 : m + 3'd1;
        j <= m == 3'(nk - IW'(1)) ? j + 4'd1 : j;
        if (last) valid <= 1'b1;
      end
    end
  end
  assign bus.o_round_key = bus.i_rk_idx > nr ? '0 :
                           {w[{rk, 2'd0}], w[{rk, 2'd1}], w[{rk, 2'd2}], w[{rk, 2'd3}]};
  assign bus.o_busy = state == EXPAND;
  assign bus.o_done = done;
  assign bus.o_key_valid = valid;
  assign bus.o_err = err;
endmodule

// File: tb/tb_key_expansion_iter.sv
// tb_key_expansion_iter: scoreboard bench for the iterative AES key expander
module tb_key_expansion_iter;
  import aes_pkg::*;
  typedef struct {
    bit err;
    int start;
    int lat;
    logic [127:0] rk;
  } exp_t;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] R128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [127:0] R192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256A = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [255:0] K256B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R256B = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  key_expansion_iter_if bus ();
  key_expansion_iter_if bus4 ();
  key_expansion_iter dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  key_expansion_iter #(.MAX_NK(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic start(input logic [1:0] len, input logic [255:0] key, input logic [3:0] idx,
                       input bit err, input int lat, input logic [127:0] rk);
    exp_t t;
    @(negedge clk);
    bus.i_key_len = len;
    bus.i_cypher_key = key;
    bus.i_rk_idx = idx;
    bus.i_start = 1'b1;
    t.err = err;
    t.start = cyc + 1;
    t.lat = lat;
    t.rk = rk;
    q.push_back(t);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic read_rk(input string name, input logic [3:0] idx, input logic [127:0] req);
    @(negedge clk);
    bus.i_rk_idx = idx;
    #1;
    check(name, bus.o_round_key, req);
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && (bus.o_done || bus.o_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%b err=%b expected none", bus.o_done, bus.o_err);
      end else begin
        e = q.pop_front();
        check("pulse_kind_err", bus.o_err, e.err);
        check("latency", cyc - e.start, e.lat);
        if (!e.err) begin
          check("round_key", bus.o_round_key, e.rk);
          check("key_valid_at_done", bus.o_key_valid, 1);
        end else check("busy_on_err", bus.o_busy, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_key_len = 2'd0;
    bus.i_cypher_key = '0;
    bus.i_rk_idx = 4'd0;
    bus4.i_start = 1'b0;
    bus4.i_key_len = 2'd0;
    bus4.i_cypher_key = '0;
    bus4.i_rk_idx = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_valid", bus.o_key_valid, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_rk0", bus.o_round_key, 0);
    rst_n = 1'b1;
    read_rk("rst_rk15", 4'd15, 0);
    // Key lengths above MAX_NK=4, and the reserved code, are rejected.
    for (int l = 1; l < 4; l++) begin
      @(negedge clk);
      bus4.i_key_len = 2'(l);
      bus4.i_start = 1'b1;
      @(posedge clk);
      #1;
      check("dut4_err", bus4.o_err, 1);
      check("dut4_busy", bus4.o_busy, 0);
      @(negedge clk);
      bus4.i_start = 1'b0;
      @(posedge clk);
      #1;
      check("dut4_err_pulse", bus4.o_err, 0);
      check("dut4_valid", bus4.o_key_valid, 0);
    end
    start(KEY_128, K128, 4'd10, 0, 40, R128);
    drain();
    read_rk("aes128_rk0", 4'd0, K128[255:128]);
    read_rk("aes128_rk11", 4'd11, 0);
    start(KEY_RSVD, K256A, 4'd10, 1, 0, 0);
    drain();
    check("rej_valid", bus.o_key_valid, 1);
    check("rej_busy", bus.o_busy, 0);
    read_rk("rej_rk10", 4'd10, R128);
    start(KEY_192, K192, 4'd12, 0, 46, R192);
    drain();
    start(KEY_256, K256A, 4'd14, 0, 52, R256A);
    drain();
    read_rk("aes256_rk15", 4'd15, 0);
    // Extra starts during EXPAND must not disturb the running schedule.
    start(KEY_256, K256B, 4'd14, 0, 52, R256B);
    repeat (10) @(negedge clk);
    bus.i_key_len = KEY_RSVD;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_key_len = KEY_128;
    bus.i_cypher_key = K128;
    @(negedge clk);
    bus.i_start = 1'b0;
    drain();
    // Start issued during the o_done cycle.
    start(KEY_128, K128, 4'd10, 0, 40, R128);
    for (int k = 0; k < 60 && !bus.o_done; k++) @(negedge clk);
    check("done_seen", bus.o_done, 1);
    bus.i_start = 1'b1;
    e.err = 1'b0;
    e.start = cyc + 1;
    e.lat = 40;
    e.rk = R128;
    q.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b0;
    check("restart_busy", bus.o_busy, 1);
    drain();
    // Reset in the middle of an AES-256 expansion.
    @(negedge clk);
    bus.i_key_len = KEY_256;
    bus.i_cypher_key = K256A;
    bus.i_rk_idx = 4'd14;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.o_busy, 0);
    check("abort_done", bus.o_done, 0);
    check("abort_valid", bus.o_key_valid, 0);
    check("abort_err", bus.o_err, 0);
    check("abort_rk", bus.o_round_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start(KEY_128, K128, 4'd10, 0, 40, R128);
    drain();
    read_rk("post_rst_rk0", 4'd0, K128[255:128]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
